// File: rtl/dragon_pkg.sv
// Shared dragon definitions: segment geometry, field offsets, orientations, reader FSM states.
package dragon_pkg;
  localparam int SEG_W    = 10;
  localparam int MAX_SEGS = 8;

  localparam int ORIENT_HI = 9;
  localparam int ORIENT_LO = 8;
  localparam int X_HI      = 7;
  localparam int X_LO      = 4;
  localparam int Y_HI      = 3;
  localparam int Y_LO      = 0;

  typedef enum logic [1:0] {
    ORIENT_UP    = 2'd0,
    ORIENT_RIGHT = 2'd1,
    ORIENT_DOWN  = 2'd2,
    ORIENT_LEFT  = 2'd3
  } orient_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
endpackage

// File: rtl/dragon_segment_reader_if.sv
// Segment stream handshake between the reader and its consumers.
interface dragon_segment_reader_if #(
  parameter int SEG_W = 10,
  parameter int IDX_W = 3
);
  logic             seg_valid;
  logic             seg_ready;
  logic [SEG_W-1:0] seg_data;
  logic [IDX_W-1:0] seg_index;
  logic             seg_last;

  modport master (output seg_valid, seg_data, seg_index, seg_last, input seg_ready);
  modport slave  (input seg_valid, seg_data, seg_index, seg_last, output seg_ready);
endinterface

// File: rtl/dragon_segment_reader_seg_mux.sv
// Combinational selector of one SEG_W slice from the packed body vector.
module seg_mux #(
  parameter int SEG_W    = 10,
  parameter int MAX_SEGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic [SEG_W*MAX_SEGS-1:0] body,
  input  logic [IDX_W-1:0]          sel,
  output logic [SEG_W-1:0]          seg
);
  always_comb begin
    seg = '0;
    for (int i = 0; i < MAX_SEGS; i++)
      if (sel == IDX_W'(i)) seg = body[i*SEG_W +: SEG_W];
  end
endmodule

// File: rtl/dragon_segment_reader.sv
// Snapshots the dragon body and streams segments head-first; flags head/body overlap at frame end.
module dragon_segment_reader #(
  parameter int SEG_W    = dragon_pkg::SEG_W,
  parameter int MAX_SEGS = dragon_pkg::MAX_SEGS,
  localparam int IDX_W   = $clog2(MAX_SEGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [SEG_W*MAX_SEGS-1:0] dragon,
  input  logic [IDX_W-1:0]          tail,
  dragon_segment_reader_if.master   seg,
  output logic                      busy,
  output logic                      done,
  output logic                      self_hit
);
  import dragon_pkg::*;

  logic [1:0]                state;
  logic [SEG_W*MAX_SEGS-1:0] snap_body;
  logic [IDX_W-1:0]          snap_tail;
  logic [IDX_W-1:0]          idx;
  logic                      hit_acc;
  logic [SEG_W-1:0]          cur_seg;
  logic                      streaming;
  logic                      is_last;
  logic                      hit_next;

  seg_mux #(.SEG_W(SEG_W), .MAX_SEGS(MAX_SEGS), .IDX_W(IDX_W)) u_mux (
    .body (snap_body),
    .sel  (idx),
    .seg  (cur_seg)
  );

  assign streaming = (state == ST_STREAM);
  assign is_last   = (idx == snap_tail);
  // Position only (x,y); the head never compares against itself.
  assign hit_next  = hit_acc |
                     ((idx != '0) && (cur_seg[X_HI:Y_LO] == snap_body[X_HI:Y_LO]));

  assign seg.seg_valid = streaming;
  assign seg.seg_data  = streaming ? cur_seg : '0;
  assign seg.seg_index = streaming ? idx : '0;
  assign seg.seg_last  = streaming && is_last;
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      snap_body <= '0;
      snap_tail <= '0;
      idx       <= '0;
      hit_acc   <= 1'b0;
      self_hit  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          snap_body <= dragon;
          snap_tail <= tail;
          idx       <= '0;
          hit_acc   <= 1'b0;
          state     <= ST_STREAM;
        end
        ST_STREAM: if (seg.seg_ready) begin
          hit_acc <= hit_next;
          // self_hit lands together with done, so fold in the final beat here.
          if (is_last) begin
            self_hit <= hit_next;
            state    <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dragon_segment_reader.sv
// Scoreboard bench for dragon_segment_reader: expected beats queued at start, checked as the DUT emits.
module tb_dragon_segment_reader;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [79:0] dragon;
  logic [2:0]  tail;
  logic        busy, done, self_hit;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [9:0] data;
    logic [2:0] idx;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mb;
  logic [79:0] body;

  dragon_segment_reader_if #(.SEG_W(10), .IDX_W(3)) sif ();

  dragon_segment_reader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dragon   (dragon),
    .tail     (tail),
    .seg      (sif),
    .busy     (busy),
    .done     (done),
    .self_hit (self_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every visible beat (stalled or not) must match the head of the queue.
  always @(negedge clk) begin
    if (reset && sif.seg_valid) begin
      if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        mb = exp_q[0];
        chk("seg_data", 32'(sif.seg_data), 32'(mb.data));
        chk("seg_index", 32'(sif.seg_index), 32'(mb.idx));
        chk("seg_last", 32'(sif.seg_last), 32'(mb.last));
        if (sif.seg_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic push_frame(input logic [79:0] b, input logic [2:0] t);
    for (int i = 0; i <= int'(t); i++) begin
      beat_t x;
      x.data = b[i*10 +: 10];
      x.idx  = 3'(i);
      x.last = (i == int'(t));
      exp_q.push_back(x);
    end
  endtask

  // Stream one frame; lat counts cycles after the start edge, ign_cyc places a stray start pulse.
  task automatic frame(input logic [79:0] b, input logic [2:0] t, input bit toggle,
                       input int exp_lat, input bit exp_hit, input int ign_cyc);
    int lat;
    bit got;
    push_frame(b, t);
    @(posedge clk); #1;
    start = 1'b1; dragon = b; tail = t; seg_ready_drive(1'b1);
    @(posedge clk); #1;
    start = 1'b0; dragon = ~b; tail = ~t;
    lat = 1; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
        start = (lat == ign_cyc);
        if (toggle) seg_ready_drive(~sif.seg_ready);
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    else begin
      chk("done_latency", lat, exp_lat);
      chk("self_hit_at_done", 32'(self_hit), 32'(exp_hit));
      chk("busy_at_done", 32'(busy), 1);
    end
    @(posedge clk); #1;
    start = 1'b0; seg_ready_drive(1'b1);
    @(negedge clk);
    chk("done_pulse_end", 32'(done), 0);
    chk("busy_idle", 32'(busy), 0);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic seg_ready_drive(input logic v);
    sif.seg_ready = v;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; dragon = '0; tail = '0; sif.seg_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(sif.seg_valid), 0);
    chk("rst_data", 32'(sif.seg_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_self_hit", 32'(self_hit), 0);
    @(posedge clk); #1; reset = 1'b1;

    // Snapshot isolation: dragon/tail are scrambled after the start edge.
    frame({50'h0, 10'h137, 10'h136, 10'h135}, 3'd2, 1'b0, 4, 1'b0, 0);

    // Self-hit on tail segment with different orientation, then held.
    frame({50'h0, 10'h035, 10'h136, 10'h135}, 3'd2, 1'b0, 4, 1'b1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("self_hit_held", 32'(self_hit), 1);
    frame({50'h0, 10'h1A7, 10'h136, 10'h135}, 3'd2, 1'b0, 4, 1'b0, 0);

    // Backpressure: ready alternates every cycle.
    frame({40'h0, 10'h0C4, 10'h2B3, 10'h1A2, 10'h391}, 3'd3, 1'b1, 8, 1'b0, 0);

    // Single segment.
    frame({70'h0, 10'h2FF}, 3'd0, 1'b0, 2, 1'b0, 0);

    // Full length with a stray start at N+4.
    for (int i = 0; i < 8; i++) body[i*10 +: 10] = {2'(i % 4), 4'(i), 4'(7 - i)};
    frame(body, 3'd7, 1'b0, 9, 1'b0, 4);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("no_second_frame", 32'(busy), 0);

    // Mid-stream reset at idx 2.
    push_frame(body, 3'd5);
    @(posedge clk); #1; start = 1'b1; dragon = body; tail = 3'd5;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("idx_before_reset", 32'(sif.seg_index), 2);
    @(posedge clk); #1; reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mrst_valid", 32'(sif.seg_valid), 0);
    chk("mrst_data", 32'(sif.seg_data), 0);
    chk("mrst_index", 32'(sif.seg_index), 0);
    chk("mrst_last", 32'(sif.seg_last), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    frame({50'h0, 10'h0A5, 10'h1B4, 10'h2C3}, 3'd2, 1'b0, 4, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
